prog_mod_counter: RTL

//  Synchronous, parametrised up/down modulo counter with a programmable prescaler, load,

---
 rtl/prog_mod_counter_pkg.sv | 9 +
 rtl/prog_mod_counter_prescaler.sv | 28 ++
 rtl/prog_mod_counter.sv | 89 ++++++++
 3 files changed

// File: rtl/prog_mod_counter_pkg.sv
// Shared terminal-mode encoding for prog_mod_counter and sibling timers.
package prog_mod_counter_pkg;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } term_mode_e;

endpackage

// File: rtl/prog_mod_counter_prescaler.sv
// Prescaler for prog_mod_counter: emits one tick per (prescale+1) enabled clocks.
module tick_prescaler #(
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] pre;

   // If prescale drops below pre, pre runs on to its maximum and rolls over to 0.
   assign tick = en && !clr && (pre == prescale);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre <= '0;
      end else if (clr) begin
         pre <= '0;
      end else if (en) begin
         pre <= tick ? '0 : pre + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/prog_mod_counter.sv
// Up/down modulo counter with prescaler, load, clear and wrap/saturate terminal mode.
module prog_mod_counter
   import prog_mod_counter_pkg::*;
#(
   parameter int unsigned WIDTH      = 28,
   parameter int unsigned PRESCALE_W = 8,
   parameter int unsigned MODE       = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic                  en,
   input  logic                  up,
   input  logic [WIDTH-1:0]      limit,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [WIDTH-1:0]      count,
   output logic                  tc,
   output logic                  at_bound
);

   localparam term_mode_e TERM_MODE = term_mode_e'(MODE[0]);
   localparam bit         SAT_MODE  = (TERM_MODE == MODE_SAT);

   logic             step;
   logic [WIDTH-1:0] count_nx;
   logic             tc_nx;
   logic [WIDTH-1:0] count_inc;
   logic [WIDTH-1:0] count_dec;

   tick_prescaler #(
      .PRESCALE_W(PRESCALE_W)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .clr     (clear | load),
      .en      (en),
      .prescale(prescale),
      .tick    (step)
   );

   assign count_inc = count + WIDTH'(1);
   assign count_dec = count - WIDTH'(1);
   assign at_bound  = (up && (count >= limit)) || (!up && (count == '0));

   always_comb begin
      count_nx = count;
      tc_nx    = 1'b0;
      if (clear) begin
         count_nx = '0;
      end else if (load) begin
         count_nx = load_val;
      end else if (step) begin
         if (up) begin
            if (count < limit) begin
               count_nx = count_inc;
               tc_nx    = SAT_MODE && (count_inc == limit);
            end else if (SAT_MODE) begin
               // Pulling an over-range count down to limit is a landing; sitting at limit is not.
               count_nx = limit;
               tc_nx    = (count != limit);
            end else begin
               count_nx = '0;
               tc_nx    = 1'b1;
            end
         end else begin
            if (count != '0) begin
               count_nx = count_dec;
               tc_nx    = SAT_MODE && (count_dec == '0);
            end else if (!SAT_MODE) begin
               count_nx = limit;
               tc_nx    = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         tc    <= 1'b0;
      end else begin
         count <= count_nx;
         tc    <= tc_nx;
      end
   end

endmodule
